// File: rtl/expression_pipe_lanes.sv
// Multi-lane pipelined ALU: S1 holds operands + opcode, S2 holds results + overflow flags.
// Optional build macro EXPR_PIPE_SATURATE_EN clamps overflowing ADD/SUB results instead of wrapping.
module expression_pipe_lanes #(
   parameter int                 LANES       = 6,
   parameter int                 W           = 6,
   parameter logic [LANES-1:0]   SIGNED_MASK = 6'b111000,
   parameter int                 CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [LANES*W-1:0]   a,
   input  logic [LANES*W-1:0]   b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   y,
   output logic [LANES-1:0]     ovf,
   output logic [CNT_W-1:0]     ovf_cnt
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_SHL = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_LT  = 3'd6;
   localparam logic [2:0] OP_EQ  = 3'd7;

   localparam logic [W-1:0]     SH_LIM  = W'(W);
   localparam logic [W-1:0]     S_MAX   = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     S_MIN   = {1'b1, {(W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 s1_v_reg;
   logic [2:0]           op_reg;
   logic [LANES*W-1:0]   a_reg;
   logic [LANES*W-1:0]   b_reg;
   logic                 s2_v_reg;
   logic [LANES*W-1:0]   y_reg;
   logic [LANES-1:0]     ovf_reg;
   logic [CNT_W-1:0]     ovf_cnt_reg;

   logic                 adv2;
   logic                 accept;
   logic                 out_fire;
   logic [LANES*W-1:0]   y_next;
   logic [LANES-1:0]     ovf_next;

   assign adv2     = !s2_v_reg || out_ready;
   assign in_ready = !s1_v_reg || adv2;
   assign accept   = in_valid && in_ready;
   assign out_fire = s2_v_reg && out_ready;

   // Per-lane datapath; signedness is fixed per lane at elaboration time.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         localparam bit LANE_S = SIGNED_MASK[gi];

         logic [W-1:0] la;
         logic [W-1:0] lb;
         logic [W:0]   sum;
         logic [W:0]   diff;
         logic [W-1:0] res;
         logic         lovf;
         logic         lt;

         assign la   = a_reg[gi*W +: W];
         assign lb   = b_reg[gi*W +: W];
         assign sum  = {1'b0, la} + {1'b0, lb};
         assign diff = {1'b0, la} - {1'b0, lb};
         assign lt   = LANE_S ? ($signed(la) < $signed(lb)) : (la < lb);

         always_comb begin
            res  = '0;
            lovf = 1'b0;
            case (op_reg)
               OP_ADD: begin
                  res  = sum[W-1:0];
                  lovf = LANE_S ? ((la[W-1] == lb[W-1]) && (sum[W-1] != la[W-1])) : sum[W];
`ifdef EXPR_PIPE_SATURATE_EN
                  if (lovf) begin
                     res = LANE_S ? (la[W-1] ? S_MIN : S_MAX) : '1;
                  end
`endif
               end
               OP_SUB: begin
                  res  = diff[W-1:0];
                  lovf = LANE_S ? ((la[W-1] != lb[W-1]) && (diff[W-1] != la[W-1])) : diff[W];
`ifdef EXPR_PIPE_SATURATE_EN
                  // The true result always carries the sign of a when a signed SUB overflows.
                  if (lovf) begin
                     res = LANE_S ? (la[W-1] ? S_MIN : S_MAX) : '0;
                  end
`endif
               end
               OP_AND: res = la & lb;
               OP_XOR: res = la ^ lb;
               OP_SHL: res = (lb >= SH_LIM) ? '0 : (la << lb);
               OP_SHR: begin
                  if (LANE_S) begin
                     res = (lb >= SH_LIM) ? {W{la[W-1]}} : W'($signed(la) >>> lb);
                  end else begin
                     res = (lb >= SH_LIM) ? '0 : (la >> lb);
                  end
               end
               OP_LT:  res = {{(W-1){1'b0}}, lt};
               OP_EQ:  res = {{(W-1){1'b0}}, (la == lb)};
               default: res = '0;
            endcase
         end

         assign y_next[gi*W +: W] = res;
         assign ovf_next[gi]      = lovf;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v_reg <= 1'b0;
         op_reg   <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
      end else if (accept) begin
         s1_v_reg <= 1'b1;
         op_reg   <= op;
         a_reg    <= a;
         b_reg    <= b;
      end else if (adv2) begin
         s1_v_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_v_reg <= 1'b0;
         y_reg    <= '0;
         ovf_reg  <= '0;
      end else if (adv2) begin
         s2_v_reg <= s1_v_reg;
         if (s1_v_reg) begin
            y_reg   <= y_next;
            ovf_reg <= ovf_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_cnt_reg <= '0;
      end else if (out_fire && (|ovf_reg) && (ovf_cnt_reg != CNT_MAX)) begin
         ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      end
   end

   assign out_valid = s2_v_reg;
   assign y         = y_reg;
   assign ovf       = ovf_reg;
   assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: tb/tb_expression_pipe_lanes.sv
// Randomized + directed bench for expression_pipe_lanes with an arithmetic reference model and scoreboard.
module tb_expression_pipe_lanes;

   localparam int LANES = 6;
   localparam int W     = 6;
   localparam logic [LANES-1:0] MASK = 6'b111000;

   typedef struct packed {
      logic [LANES*W-1:0] y;
      logic [LANES-1:0]   ovf;
   } beat_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready, in_ready2;
   logic [2:0]         op = '0;
   logic [LANES*W-1:0] a = '0, b = '0;
   logic               out_valid, out_valid2;
   logic               out_ready = 1'b1;
   logic [LANES*W-1:0] y, y2;
   logic [LANES-1:0]   ovf, ovf2;
   logic [15:0]        ovf_cnt;
   logic [1:0]         ovf_cnt2;

   int total = 0;
   int bad = 0;
   bit mon_en = 1'b0;
   beat_t q[$];
   int cnt_model = 0;
   int cnt2_model = 0;
   int fires = 0;

   always #5 clk = ~clk;

   expression_pipe_lanes #(.LANES(LANES), .W(W), .SIGNED_MASK(MASK), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf),
      .ovf_cnt(ovf_cnt));

   expression_pipe_lanes #(.LANES(LANES), .W(W), .SIGNED_MASK(MASK), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
      .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .ovf(ovf2),
      .ovf_cnt(ovf_cnt2));

   // Reference: evaluate the true mathematical result, then range-check and truncate.
   function automatic logic [W:0] lane_model(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] z, input bit s);
      int m, av, bv, bu, lo, hi, r, p;
      logic [W-1:0] yv;
      logic ov;
      m  = 1 << W;
      av = (s && x[W-1]) ? int'(x) - m : int'(x);
      bv = (s && z[W-1]) ? int'(z) - m : int'(z);
      bu = int'(z);
      lo = s ? -(m / 2) : 0;
      hi = s ? (m / 2 - 1) : (m - 1);
      ov = 1'b0;
      yv = '0;
      case (o)
         3'd0, 3'd1: begin
            r  = (o == 3'd0) ? av + bv : av - bv;
            ov = (r < lo) || (r > hi);
            yv = W'(r);
`ifdef EXPR_PIPE_SATURATE_EN
            if (r > hi) yv = W'(hi);
            else if (r < lo) yv = W'(lo);
`endif
         end
         3'd2: yv = x & z;
         3'd3: yv = x ^ z;
         3'd4: yv = (bu >= W) ? '0 : W'(int'(x) * (1 << bu));
         3'd5: begin
            if (!s) yv = (bu >= W) ? '0 : W'(int'(x) / (1 << bu));
            else if (bu >= W) yv = (av < 0) ? '1 : '0;
            else begin
               p  = 1 << bu;
               r  = (av < 0) ? (av - (p - 1)) / p : av / p;
               yv = W'(r);
            end
         end
         3'd6: yv = (av < bv) ? W'(1) : W'(0);
         default: yv = (x == z) ? W'(1) : W'(0);
      endcase
      return {ov, yv};
   endfunction

   function automatic beat_t model_beat(input logic [2:0] o, input logic [LANES*W-1:0] x,
                                        input logic [LANES*W-1:0] z);
      beat_t e;
      logic [W:0] r;
      for (int i = 0; i < LANES; i++) begin
         r = lane_model(o, x[i*W +: W], z[i*W +: W], MASK[i]);
         e.y[i*W +: W] = r[W-1:0];
         e.ovf[i]      = r[W];
      end
      return e;
   endfunction

   // Scoreboard: handshakes observed at the falling edge take effect on the next rising edge.
   always @(negedge clk) begin
      beat_t e;
      if (mon_en) begin
         total++;
         if (ovf_cnt !== 16'(cnt_model)) begin
            bad++;
            $display("FAIL ovf_cnt got=%0d exp=%0d t=%0t", ovf_cnt, cnt_model, $time);
         end
         total++;
         if (ovf_cnt2 !== 2'(cnt2_model)) begin
            bad++;
            $display("FAIL ovf_cnt_w2 got=%0d exp=%0d t=%0t", ovf_cnt2, cnt2_model, $time);
         end
         if (reset) begin
            q.delete();
            cnt_model  = 0;
            cnt2_model = 0;
         end else begin
            if (out_valid && out_ready) begin
               fires++;
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL spurious_beat got y=%h exp=none t=%0t", y, $time);
               end else begin
                  e = q.pop_front();
                  if (y !== e.y || ovf !== e.ovf) begin
                     bad++;
                     $display("FAIL beat got y=%h ovf=%b exp y=%h ovf=%b t=%0t", y, ovf, e.y, e.ovf, $time);
                  end else begin
                     $display("beat ok y=%h ovf=%b", y, ovf);
                  end
                  if (|e.ovf) begin
                     if (cnt_model < 65535) cnt_model++;
                     if (cnt2_model < 3) cnt2_model++;
                  end
               end
            end
            if (in_valid && in_ready) q.push_back(model_beat(op, a, b));
         end
      end
   end

   // Present a beat (called at posedge+1) and hold it until accepted.
   task automatic drive(input logic [2:0] o, input logic [LANES*W-1:0] x, input logic [LANES*W-1:0] z);
      int n = 0;
      in_valid = 1'b1; op = o; a = x; b = z;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL drive_timeout got in_ready=0 exp=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [LANES*W-1:0] yo, output logic [LANES-1:0] ov);
      int n = 0;
      @(negedge clk);
      while (!(out_valid && out_ready) && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!out_valid) begin
         total++; bad++;
         $display("FAIL wait_out_timeout got out_valid=0 exp=1");
      end
      yo = y; ov = ovf;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1; in_valid = 1'b0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d exp=0", q.size());
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || y !== '0 || ovf !== '0 || ovf_cnt !== '0) begin
         bad++;
         $display("FAIL reset_state got v=%b y=%h ovf=%b cnt=%0d exp all 0", out_valid, y, ovf, ovf_cnt);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      mon_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_add_latency();
      logic [LANES*W-1:0] xa, xb;
      xa = '0; xb = '0;
      xa[5:0] = 6'd20; xb[5:0] = 6'd30;
      out_ready = 1'b1;
      @(posedge clk); #1;
      drive(3'd0, xa, xb);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_latency_early got out_valid=%b exp=0", out_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || y[5:0] !== 6'd50 || ovf !== '0) begin
         bad++;
         $display("FAIL add_basic got v=%b y0=%0d ovf=%b exp v=1 y0=50 ovf=0", out_valid, y[5:0], ovf);
      end
      @(posedge clk); #1;
      $display("add latency checked");
   endtask

   task automatic test_signed_ovf();
      logic [LANES*W-1:0] xa, xb, yo;
      logic [LANES-1:0] ov;
      logic [W-1:0] exp5;
      xa = '0; xb = '0;
      xa[35:30] = 6'd31; xb[35:30] = 6'd1;
`ifdef EXPR_PIPE_SATURATE_EN
      exp5 = 6'd31;
`else
      exp5 = 6'b100000;
`endif
      drive(3'd0, xa, xb);
      wait_out(yo, ov);
      total++;
      if (yo[35:30] !== exp5 || ov !== 6'b100000) begin
         bad++;
         $display("FAIL signed_add_ovf got y5=%b ovf=%b exp y5=%b ovf=100000", yo[35:30], ov, exp5);
      end
      @(negedge clk);
      total++;
      if (ovf_cnt !== 16'd1) begin
         bad++;
         $display("FAIL ovf_cnt_first got=%0d exp=1", ovf_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_shr_lt();
      logic [LANES*W-1:0] xa, xb, yo;
      logic [LANES-1:0] ov;
      logic [W-1:0] amt [2];
      logic [W-1:0] e0 [2];
      logic [W-1:0] e3 [2];
      amt[0] = 6'd2; e0[0] = 6'b001000; e3[0] = 6'b111000;
      amt[1] = 6'd7; e0[1] = 6'b000000; e3[1] = 6'b111111;
      for (int k = 0; k < 2; k++) begin
         xa = {LANES{6'b100000}};
         xb = {LANES{amt[k]}};
         drive(3'd5, xa, xb);
         wait_out(yo, ov);
         total++;
         if (yo[5:0] !== e0[k] || yo[23:18] !== e3[k] || ov !== '0) begin
            bad++;
            $display("FAIL shr_b%0d got l0=%b l3=%b exp l0=%b l3=%b", amt[k], yo[5:0], yo[23:18], e0[k], e3[k]);
         end
      end
      xa = {LANES{6'b111111}};
      xb = {LANES{6'd1}};
      drive(3'd6, xa, xb);
      wait_out(yo, ov);
      total++;
      if (yo[5:0] !== 6'd0 || yo[35:30] !== 6'd1) begin
         bad++;
         $display("FAIL lt_signedness got l0=%0d l5=%0d exp l0=0 l5=1", yo[5:0], yo[35:30]);
      end
   endtask

   task automatic test_back_to_back();
      logic [LANES*W-1:0] xa [4];
      beat_t e1;
      int f0, n;
      for (int k = 0; k < 4; k++) xa[k] = {LANES{W'(k + 1)}};
      e1 = model_beat(3'd3, xa[0], {LANES{6'd5}});
      f0 = fires;
      out_ready = 1'b0;
      drive(3'd3, xa[0], {LANES{6'd5}});
      drive(3'd3, xa[1], {LANES{6'd5}});
      in_valid = 1'b1; op = 3'd3; a = xa[2]; b = {LANES{6'd5}};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== e1.y) begin
            bad++;
            $display("FAIL stall_hold c=%0d got rdy=%b v=%b y=%h exp rdy=0 v=1 y=%h", c, in_ready, out_valid, y, e1.y);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 10) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk); #1;
      drive(3'd3, xa[3], {LANES{6'd5}});
      drain();
      total++;
      if (fires - f0 != 4) begin
         bad++;
         $display("FAIL stream_count got=%0d exp=4", fires - f0);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      drive(3'd0, {LANES{6'd63}}, {LANES{6'd1}});
      drive(3'd0, {LANES{6'd63}}, {LANES{6'd1}});
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || ovf_cnt !== '0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=1", out_valid, ovf_cnt, in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_beat c=%0d got out_valid=1 exp=0", c);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cnt_saturate();
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) drive(3'(k % 2), {LANES{6'd31}}, {LANES{6'd33}});
      drain();
      @(negedge clk);
      total++;
      if (ovf_cnt2 !== 2'd3 || ovf_cnt !== 16'd5) begin
         bad++;
         $display("FAIL cnt_saturate got w2=%0d w16=%0d exp w2=3 w16=5", ovf_cnt2, ovf_cnt);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         op = 3'($urandom_range(0, 7));
         for (int i = 0; i < LANES; i++) begin
            a[i*W +: W] = W'($urandom);
            b[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8)) : W'($urandom);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_signed_ovf();
      test_shr_lt();
      test_back_to_back();
      test_reset_midstream();
      test_cnt_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
